// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, baud indices,
// and the bit-time lookup used to program the bit timer.
package uart_rx_engine_pkg;

  localparam int TIMER_W = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [3:0] BAUD_300    = 4'd0;
  localparam logic [3:0] BAUD_1200   = 4'd1;
  localparam logic [3:0] BAUD_2400   = 4'd2;
  localparam logic [3:0] BAUD_4800   = 4'd3;
  localparam logic [3:0] BAUD_9600   = 4'd4;
  localparam logic [3:0] BAUD_19200  = 4'd5;
  localparam logic [3:0] BAUD_38400  = 4'd6;
  localparam logic [3:0] BAUD_57600  = 4'd7;
  localparam logic [3:0] BAUD_115200 = 4'd8;
  localparam logic [3:0] BAUD_230400 = 4'd9;
  localparam logic [3:0] BAUD_460800 = 4'd10;

  // Clocks per bit, rounded to nearest; indices above 10 all mean 921600 baud.
  function automatic logic [TIMER_W-1:0] bit_time(input logic [3:0] idx, input int clk_freq);
    int baud;
    case (idx)
      BAUD_300:    baud = 300;
      BAUD_1200:   baud = 1200;
      BAUD_2400:   baud = 2400;
      BAUD_4800:   baud = 4800;
      BAUD_9600:   baud = 9600;
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      BAUD_230400: baud = 230400;
      BAUD_460800: baud = 460800;
      default:     baud = 921600;
    endcase
    bit_time = TIMER_W'((clk_freq + baud / 2) / baud);
  endfunction

endpackage

// File: rtl/uart_rx_engine_bit_timer.sv
// Down-counting bit timer: pulses expire for one clock when the count reaches 1,
// then reloads from load_val so successive pulses are exactly load_val clocks apart.
module uart_rx_engine_bit_timer
  import uart_rx_engine_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] load_val,
  input  logic         load,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;

  assign expire = en & ~load & (count == W'(1));

  // Count down while enabled; explicit load wins, reload on expiry (0 also reloads, never wraps).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (count <= W'(1)) count <= load_val;
      else                count <= count - W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive core: synchronizes RX, frames start/data/parity/stop bits and
// presents each byte with error flags until the consumer acknowledges it.
// Handshake: rx_rdy rises with a new byte and stays high until a cycle with
// rx_read=1; that cycle clears rx_rdy and the flags unless a frame completes in
// the same cycle, in which case the new byte is presented instead.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud_value,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       RX,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic [2:0] state_dbg
);

  rx_state_e            state, state_next;
  logic                 rx_meta, rxs, rxs_d;
  logic                 fall;
  logic [3:0]           baud_lat;
  logic                 eight_lat, pen_lat, ohel_lat;
  logic [7:0]           shreg;
  logic [3:0]           bit_cnt;
  logic                 par_acc;
  logic                 perr_n;
  logic                 start_det, shift_en, par_smp, frame_done;
  logic [TIMER_W-1:0]   t_load_val;
  logic                 expire;

  assign fall      = rxs_d & ~rxs;
  assign state_dbg = state;

  // First half-bit is timed from the live switches; every later bit uses the latched rate.
  assign t_load_val = (state == ST_IDLE) ? (bit_time(baud_value, CLK_FREQ) >> 1)
                                         : bit_time(baud_lat, CLK_FREQ);

  uart_rx_engine_bit_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_val (t_load_val),
    .load     (start_det),
    .en       (state != ST_IDLE),
    .expire   (expire)
  );

  // Two-flop synchronizer plus one-clock history for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and per-sample strobes; every action happens on a timer expiry except start detection.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    par_smp    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          start_det  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (expire) state_next = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (expire) begin
          shift_en = 1'b1;
          if (bit_cnt == (eight_lat ? 4'd7 : 4'd6))
            state_next = pen_lat ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (expire) begin
          par_smp    = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (expire) begin
          frame_done = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: format latch at start, LSB-first shift, running parity, parity verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_lat  <= 4'd0;
      eight_lat <= 1'b0;
      pen_lat   <= 1'b0;
      ohel_lat  <= 1'b0;
      shreg     <= 8'd0;
      bit_cnt   <= 4'd0;
      par_acc   <= 1'b0;
      perr_n    <= 1'b0;
    end else begin
      if (start_det) begin
        baud_lat  <= baud_value;
        eight_lat <= EIGHT;
        pen_lat   <= PEN;
        ohel_lat  <= OHEL;
        bit_cnt   <= 4'd0;
        par_acc   <= 1'b0;
        perr_n    <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_cnt <= bit_cnt + 4'd1;
        par_acc <= par_acc ^ rxs;
      end
      if (par_smp) perr_n <= ((par_acc ^ rxs) != ohel_lat);
    end
  end

  // Output holding registers; a completing frame takes priority over the consumer's read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= 8'd0;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (frame_done) begin
      rx_data <= eight_lat ? shreg : {1'b0, shreg[7:1]};
      perr    <= pen_lat & perr_n;
      ferr    <= ~rxs;
      rx_rdy  <= 1'b1;
      ovf     <= rx_rdy & ~rx_read;
    end else if (rx_read && rx_rdy) begin
      rx_rdy <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      ovf    <= 1'b0;
    end
  end

endmodule
